// File: rtl/german_pkg.sv
// Shared types for the German coherence protocol: message commands,
// cache-line states and the {cmd, data} message record.
package german_pkg;

    localparam int DATA_W = 2;

    typedef enum logic [2:0] {
        CMD_EMPTY  = 3'd0,
        CMD_REQS   = 3'd1,
        CMD_REQE   = 3'd2,
        CMD_INV    = 3'd3,
        CMD_INVACK = 3'd4,
        CMD_GNTS   = 3'd5,
        CMD_GNTE   = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_E = 2'd2
    } line_state_t;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_REQ  = 2'd1,
        FSM_WAIT = 2'd2
    } agent_fsm_t;

    typedef struct packed {
        cmd_t              cmd;
        logic [DATA_W-1:0] data;
    } msg_t;

endpackage

// File: rtl/german_cache_agent_if.sv
// CPU, Chan1/2/3 and line-status bundle of one cache agent.
// slave = agent side, master = CPU plus home side.
interface german_cache_agent_if
    import german_pkg::*;
#(
    parameter int DATA_W = german_pkg::DATA_W
) ();

    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_store;
    logic [DATA_W-1:0] cpu_req_data;
    logic              cpu_rsp_valid;
    logic [DATA_W-1:0] cpu_rsp_data;

    logic              chan1_valid;
    logic              chan1_ready;
    cmd_t              chan1_cmd;

    logic              chan2_valid;
    logic              chan2_ready;
    cmd_t              chan2_cmd;
    logic [DATA_W-1:0] chan2_data;

    logic              chan3_valid;
    logic              chan3_ready;
    cmd_t              chan3_cmd;
    logic [DATA_W-1:0] chan3_data;

    logic [1:0]        cache_state;
    logic [DATA_W-1:0] cache_data;
    logic              proto_err;

    modport slave (
        input  cpu_req_valid, cpu_req_store, cpu_req_data,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
        output chan1_valid, chan1_cmd,
        input  chan1_ready,
        input  chan2_valid, chan2_cmd, chan2_data,
        output chan2_ready,
        output chan3_valid, chan3_cmd, chan3_data,
        input  chan3_ready,
        output cache_state, cache_data, proto_err
    );

    modport master (
        output cpu_req_valid, cpu_req_store, cpu_req_data,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
        input  chan1_valid, chan1_cmd,
        output chan1_ready,
        output chan2_valid, chan2_cmd, chan2_data,
        input  chan2_ready,
        input  chan3_valid, chan3_cmd, chan3_data,
        output chan3_ready,
        input  cache_state, cache_data, proto_err
    );

endinterface

// File: rtl/german_msg_slot.sv
// Single-entry registered valid/ready output slot; a load in the
// handshake cycle replaces the departing message without a bubble.
module german_msg_slot #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_msg,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] msg
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            msg   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            msg   <= load_msg;
        end else if (valid && ready) begin
            valid <= 1'b0;
            msg   <= '0;
        end
    end

endmodule

// File: rtl/german_cache_agent.sv
// Node-side German protocol agent: one cache line, CPU front end,
// ReqS/ReqE issue on Chan1, grant/Inv intake on Chan2, InvAck on Chan3.
module german_cache_agent
    import german_pkg::*;
#(
    parameter int DATA_W = german_pkg::DATA_W
) (
    input logic                 clock,
    input logic                 reset,
    german_cache_agent_if.slave bus
);

    agent_fsm_t        fsm_q, fsm_d;
    line_state_t       st_q, st_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pst_q, pst_d;
    logic [DATA_W-1:0] pdat_q, pdat_d;
    logic              rspv_q, rspv_d;
    logic [DATA_W-1:0] rspd_q, rspd_d;
    logic              err_q, err_d;

    logic              c1_load;
    cmd_t              c1_cmd;
    logic [2:0]        c1_msg;
    logic              c3_load;
    logic [DATA_W-1:0] c3_data;
    logic [DATA_W+2:0] c3_msg;
    logic              c3_busy;
    logic              is_inv;
    logic              c2_fire;
    logic              cpu_fire;
    logic              in_wait;

    assign is_inv   = bus.chan2_cmd == CMD_INV;
    assign in_wait  = fsm_q == FSM_WAIT;
    // Chan3 counts as free in the cycle its handshake completes.
    assign c3_busy  = bus.chan3_valid && !bus.chan3_ready;
    assign bus.chan2_ready =
        !(bus.chan2_valid && is_inv && c3_busy);
    assign c2_fire  = bus.chan2_valid && bus.chan2_ready;
    assign bus.cpu_req_ready = (fsm_q == FSM_IDLE) && !c2_fire;
    assign cpu_fire = bus.cpu_req_valid && bus.cpu_req_ready;

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        data_d  = data_q;
        pst_d   = pst_q;
        pdat_d  = pdat_q;
        rspv_d  = 1'b0;
        rspd_d  = rspd_q;
        err_d   = err_q;
        c1_load = 1'b0;
        c1_cmd  = CMD_REQS;
        c3_load = 1'b0;
        c3_data = '0;

        if (fsm_q == FSM_REQ && bus.chan1_valid && bus.chan1_ready)
            fsm_d = FSM_WAIT;

        if (c2_fire) begin
            unique case (1'b1)
                is_inv: begin
                    c3_load = 1'b1;
                    c3_data = (st_q == ST_E) ? data_q : '0;
                    st_d    = ST_I;
                end
                in_wait && bus.chan2_cmd == CMD_GNTS: begin
                    st_d   = ST_S;
                    data_d = bus.chan2_data;
                    rspv_d = 1'b1;
                    rspd_d = bus.chan2_data;
                    fsm_d  = FSM_IDLE;
                end
                in_wait && bus.chan2_cmd == CMD_GNTE: begin
                    st_d   = ST_E;
                    data_d = pst_q ? pdat_q : bus.chan2_data;
                    rspv_d = 1'b1;
                    rspd_d = pst_q ? pdat_q : bus.chan2_data;
                    fsm_d  = FSM_IDLE;
                end
                default: err_d = 1'b1;
            endcase
        end else if (cpu_fire) begin
            unique case (1'b1)
                !bus.cpu_req_store && st_q != ST_I: begin
                    rspv_d = 1'b1;
                    rspd_d = data_q;
                end
                bus.cpu_req_store && st_q == ST_E: begin
                    data_d = bus.cpu_req_data;
                    rspv_d = 1'b1;
                    rspd_d = bus.cpu_req_data;
                end
                !bus.cpu_req_store && st_q == ST_I: begin
                    pst_d   = 1'b0;
                    c1_load = 1'b1;
                    c1_cmd  = CMD_REQS;
                    fsm_d   = FSM_REQ;
                end
                default: begin
                    pst_d   = 1'b1;
                    pdat_d  = bus.cpu_req_data;
                    c1_load = 1'b1;
                    c1_cmd  = CMD_REQE;
                    fsm_d   = FSM_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q  <= FSM_IDLE;
            st_q   <= ST_I;
            data_q <= '0;
            pst_q  <= 1'b0;
            pdat_q <= '0;
            rspv_q <= 1'b0;
            rspd_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            data_q <= data_d;
            pst_q  <= pst_d;
            pdat_q <= pdat_d;
            rspv_q <= rspv_d;
            rspd_q <= rspd_d;
            err_q  <= err_d;
        end
    end

    german_msg_slot #(.W(3)) u_chan1 (
        .clock    (clock),
        .reset    (reset),
        .load     (c1_load),
        .load_msg (c1_cmd),
        .ready    (bus.chan1_ready),
        .valid    (bus.chan1_valid),
        .msg      (c1_msg)
    );

    german_msg_slot #(.W(DATA_W + 3)) u_chan3 (
        .clock    (clock),
        .reset    (reset),
        .load     (c3_load),
        .load_msg ({CMD_INVACK, c3_data}),
        .ready    (bus.chan3_ready),
        .valid    (bus.chan3_valid),
        .msg      (c3_msg)
    );

    assign bus.chan1_cmd     = cmd_t'(c1_msg);
    assign bus.chan3_cmd     = cmd_t'(c3_msg[DATA_W+2:DATA_W]);
    assign bus.chan3_data    = c3_msg[DATA_W-1:0];
    assign bus.cpu_rsp_valid = rspv_q;
    assign bus.cpu_rsp_data  = rspd_q;
    assign bus.cache_state   = st_q;
    assign bus.cache_data    = data_q;
    assign bus.proto_err     = err_q;

endmodule

// File: tb/tb_german_cache_agent.sv
// Bench for german_cache_agent: CPU op table with a response
// scoreboard, plus hand-written Inv, error and reset sequences.
module tb_german_cache_agent;
    import german_pkg::*;

    typedef struct {
        logic       store;
        logic [1:0] data;
        logic       inv_wait;
        cmd_t       exp_req;
        cmd_t       gnt;
        logic [1:0] gdata;
        logic [1:0] exp_st;
        logic [1:0] exp_data;
        logic [1:0] exp_rsp;
    } vec_t;

    logic clock = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [1:0] q[$];
    vec_t tbl[9];

    german_cache_agent_if #(.DATA_W(2)) bus ();

    german_cache_agent #(.DATA_W(2)) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, act, exp);
        end
    endtask

    // Response scoreboard: every pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (bus.cpu_rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected actual=%0d required=none",
                         bus.cpu_rsp_data);
            end else begin
                chk("rsp_data", bus.cpu_rsp_data, q.pop_front());
            end
        end
    end

    task automatic chk_reset(input string t);
        chk({t, "_req_ready"}, bus.cpu_req_ready, 1);
        chk({t, "_rsp_valid"}, bus.cpu_rsp_valid, 0);
        chk({t, "_c1_valid"}, bus.chan1_valid, 0);
        chk({t, "_c1_cmd"}, bus.chan1_cmd, 0);
        chk({t, "_c3_valid"}, bus.chan3_valid, 0);
        chk({t, "_c3_cmd"}, bus.chan3_cmd, 0);
        chk({t, "_c3_data"}, bus.chan3_data, 0);
        chk({t, "_state"}, bus.cache_state, 0);
        chk({t, "_data"}, bus.cache_data, 0);
        chk({t, "_err"}, bus.proto_err, 0);
    endtask

    task automatic do_op(input vec_t v, input int i);
        @(negedge clock);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_store = v.store;
        bus.cpu_req_data  = v.data;
        #1 chk($sformatf("op%0d_req_ready", i),
               bus.cpu_req_ready, 1);
        if (v.exp_req == CMD_EMPTY) q.push_back(v.exp_rsp);
        @(negedge clock);
        bus.cpu_req_valid = 1'b0;
        #1 chk($sformatf("op%0d_c1_valid", i),
               bus.chan1_valid, v.exp_req != CMD_EMPTY);
        if (v.exp_req != CMD_EMPTY) begin
            chk($sformatf("op%0d_c1_cmd", i),
                bus.chan1_cmd, v.exp_req);
            bus.chan1_ready = 1'b1;
            @(negedge clock);
            bus.chan1_ready = 1'b0;
            if (v.inv_wait) begin
                bus.chan2_valid = 1'b1;
                bus.chan2_cmd   = CMD_INV;
                bus.chan2_data  = 2'd0;
                bus.chan3_ready = 1'b1;
                @(negedge clock);
                bus.chan2_valid = 1'b0;
                #1 chk("wi_c3_valid", bus.chan3_valid, 1);
                chk("wi_c3_cmd", bus.chan3_cmd, 4);
                chk("wi_c3_data", bus.chan3_data, 0);
                chk("wi_state", bus.cache_state, 0);
                chk("wi_req_ready", bus.cpu_req_ready, 0);
                @(negedge clock);
                bus.chan3_ready = 1'b0;
                #1 chk("wi_c3_drop", bus.chan3_valid, 0);
            end
            bus.chan2_valid = 1'b1;
            bus.chan2_cmd   = v.gnt;
            bus.chan2_data  = v.gdata;
            #1 chk($sformatf("op%0d_c2_ready", i),
                   bus.chan2_ready, 1);
            q.push_back(v.exp_rsp);
            @(negedge clock);
            bus.chan2_valid = 1'b0;
            #1;
        end
        chk($sformatf("op%0d_state", i), bus.cache_state, v.exp_st);
        chk($sformatf("op%0d_data", i), bus.cache_data, v.exp_data);
        chk($sformatf("op%0d_rsp_left", i), q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 0, CMD_REQS,  CMD_GNTS,  2, 1, 2, 2};
        tbl[1] = '{0, 0, 0, CMD_EMPTY, CMD_EMPTY, 0, 1, 2, 2};
        tbl[2] = '{1, 1, 0, CMD_REQE,  CMD_GNTE,  3, 2, 1, 1};
        tbl[3] = '{1, 2, 0, CMD_EMPTY, CMD_EMPTY, 0, 2, 2, 2};
        tbl[4] = '{0, 0, 0, CMD_EMPTY, CMD_EMPTY, 0, 2, 2, 2};
        tbl[5] = '{1, 3, 0, CMD_EMPTY, CMD_EMPTY, 0, 2, 3, 3};
        tbl[6] = '{0, 0, 0, CMD_REQS,  CMD_GNTS,  1, 1, 1, 1};
        tbl[7] = '{1, 2, 1, CMD_REQE,  CMD_GNTE,  3, 2, 2, 2};
        tbl[8] = '{0, 0, 0, CMD_REQS,  CMD_GNTE,  1, 2, 1, 1};

        rst_n = 1'b0;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_store = 1'b0;
        bus.cpu_req_data  = 2'd0;
        bus.chan1_ready   = 1'b0;
        bus.chan2_valid   = 1'b0;
        bus.chan2_cmd     = CMD_EMPTY;
        bus.chan2_data    = 2'd0;
        bus.chan3_ready   = 1'b0;
        repeat (2) @(negedge clock);
        #1 chk_reset("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) do_op(tbl[i], i);

        // Inv on E line, InvAck stalled, second Inv held off.
        @(negedge clock);
        bus.chan2_valid = 1'b1;
        bus.chan2_cmd   = CMD_INV;
        bus.chan2_data  = 2'd0;
        #1 chk("inv_c2_ready", bus.chan2_ready, 1);
        @(negedge clock);
        bus.chan2_valid = 1'b0;
        #1 chk("inv_c3_valid", bus.chan3_valid, 1);
        chk("inv_c3_cmd", bus.chan3_cmd, 4);
        chk("inv_c3_data", bus.chan3_data, 3);
        chk("inv_state", bus.cache_state, 0);
        repeat (2) @(negedge clock);
        #1 chk("inv_hold_valid", bus.chan3_valid, 1);
        chk("inv_hold_data", bus.chan3_data, 3);
        bus.chan2_valid = 1'b1;
        bus.chan2_cmd   = CMD_INV;
        #1 chk("inv2_stall", bus.chan2_ready, 0);
        @(negedge clock);
        #1 chk("inv2_stall2", bus.chan2_ready, 0);
        bus.chan3_ready = 1'b1;
        #1 chk("inv2_accept", bus.chan2_ready, 1);
        @(negedge clock);
        bus.chan2_valid = 1'b0;
        bus.chan3_ready = 1'b0;
        #1 chk("inv2_c3_valid", bus.chan3_valid, 1);
        chk("inv2_c3_cmd", bus.chan3_cmd, 4);
        chk("inv2_c3_data", bus.chan3_data, 0);
        bus.chan3_ready = 1'b1;
        @(negedge clock);
        bus.chan3_ready = 1'b0;
        #1 chk("inv2_c3_drop", bus.chan3_valid, 0);

        for (int i = 6; i < 8; i++) do_op(tbl[i], i);

        // Grant with nothing outstanding.
        @(negedge clock);
        bus.chan2_valid = 1'b1;
        bus.chan2_cmd   = CMD_GNTS;
        bus.chan2_data  = 2'd1;
        #1 chk("gidle_c2_ready", bus.chan2_ready, 1);
        @(negedge clock);
        bus.chan2_valid = 1'b0;
        #1 chk("gidle_err", bus.proto_err, 1);
        chk("gidle_state", bus.cache_state, 2);
        chk("gidle_data", bus.cache_data, 2);

        // Inv collides with a store hit; the store retries as a miss.
        bus.chan3_ready   = 1'b1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_store = 1'b1;
        bus.cpu_req_data  = 2'd1;
        bus.chan2_valid   = 1'b1;
        bus.chan2_cmd     = CMD_INV;
        #1 chk("coll_req_ready", bus.cpu_req_ready, 0);
        @(negedge clock);
        bus.chan2_valid = 1'b0;
        #1 chk("coll_state", bus.cache_state, 0);
        chk("coll_c3_data", bus.chan3_data, 2);
        chk("coll_retry_ready", bus.cpu_req_ready, 1);
        @(negedge clock);
        bus.cpu_req_valid = 1'b0;
        #1 chk("coll_c1_valid", bus.chan1_valid, 1);
        chk("coll_c1_cmd", bus.chan1_cmd, 2);
        bus.chan1_ready = 1'b1;
        @(negedge clock);
        bus.chan1_ready = 1'b0;
        bus.chan3_ready = 1'b0;
        #1 chk("coll_c1_drop", bus.chan1_valid, 0);
        chk("coll_wait_busy", bus.cpu_req_ready, 0);

        // Reset in WAIT drops the pending store silently.
        rst_n = 1'b0;
        #1 chk_reset("mid");
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        do_op(tbl[8], 8);

        repeat (2) @(negedge clock);
        #1 chk("final_rsp_left", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/german_cache_agent.md
# german_cache_agent

Client-side agent for one cache node of the German coherence protocol. It turns CPU load/store requests into ReqS/ReqE messages on Chan1, consumes GntS/GntE/Inv from the home on Chan2, and returns InvAck on Chan3. It holds one cache line (state plus data). It is the node-side counterpart of the home/directory logic in `system`, and one instance per node replaces the nondeterministic rule-select driving of that model.

## Interface
- `DATA_W`, default 2: width of the data value.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `cpu_req_valid`  in  1  CPU request present.
- `cpu_req_ready`  out  1  agent accepts the request this cycle.
- `cpu_req_store`  in  1  1 = store, 0 = load.
- `cpu_req_data`  in  DATA_W  store data.
- `cpu_rsp_valid`  out  1  one-cycle completion pulse.
- `cpu_rsp_data`  out  DATA_W  load result; for a store, the value written.
- `chan1_valid` / `chan1_ready`  out / in  1  request channel to the home.
- `chan1_cmd`  out  3  request command: ReqS or ReqE.
- `chan2_valid` / `chan2_ready`  in / out  1  home-to-node channel.
- `chan2_cmd` / `chan2_data`  in  3 / DATA_W  Inv, GntS or GntE, plus data.
- `chan3_valid` / `chan3_ready`  out / in  1  InvAck channel to the home.
- `chan3_cmd` / `chan3_data`  out  3 / DATA_W  InvAck plus data.
- `cache_state`  out  2  I=0, S=1, E=2.
- `cache_data`  out  DATA_W  current line data.
- `proto_err`  out  1  sticky error flag.

## Operation
- Command encoding: Empty=0, ReqS=1, ReqE=2, Inv=3, InvAck=4, GntS=5, GntE=6.
- FSM states:
  - IDLE: accepts CPU requests.
  - REQ: `chan1_valid` is high, waiting for `chan1_ready`.
  - WAIT: request sent, waiting for a grant.
- CPU request handling, IDLE only:
  - Load hit (S or E): `cpu_rsp_valid` with `cache_data` on the next cycle.
  - Store hit (E only): `cache_data` <= `cpu_req_data`, then response.
  - Load in I: latch the request and issue ReqS.
  - Store in S or I: latch the request and issue ReqE. Tracked state is unchanged until the grant arrives.
- Grant handling, WAIT only:
  - GntS: state S, data <= `chan2_data`, response with that data.
  - GntE: state E, data <= `chan2_data`; a pending store then overwrites the data with the latched store value. Response follows.
  - After either grant the FSM returns to IDLE.
- Inv, accepted in any FSM state when the Chan3 output register is empty:
  - Load `chan3_cmd` = InvAck and `chan3_data` = `cache_data` if the line is E, else 0.
  - State <= I.
  - The FSM is not disturbed: a pending ReqE or ReqS still waits for its grant.
- Error cases: a grant outside WAIT, or an Empty/Req/InvAck command on Chan2, sets `proto_err`. The message is consumed and dropped. `proto_err` clears only on reset.
- `cpu_req_ready` = FSM in IDLE and no Chan2 message being accepted in the same cycle. An incoming Inv has priority over a CPU request.

## Timing
- Reset values: every valid output 0, `cpu_req_ready` 1, `cache_state` I, `cache_data` 0, `chan*_cmd` Empty, `chan*_data` 0, `proto_err` 0, FSM IDLE.
- Chan1 and Chan3 outputs are registered.
  - `valid` is asserted the cycle after the triggering event.
  - `valid`, `cmd` and `data` hold stable until `ready` is sampled high.
  - `valid` drops the cycle after that handshake.
- Hit latency: request accepted in cycle N, response in N+1.
- Miss latency: request accepted in N; `chan1_valid` asserted in N+1.
- Grant handshake in cycle M gives `cpu_rsp_valid` and the updated state in M+1.
- `chan2_ready` is combinational: high unless an Inv arrives while Chan3 is still occupied.
  - A new Inv may be accepted in the same cycle that the Chan3 handshake completes.
- Inv and a CPU store hit in the same cycle: the Inv wins and the store stalls. The store is re-evaluated next cycle, now as a miss.
- Reset asserted mid-transaction: all state clears immediately. The pending CPU request is lost with no response.

## Structure
- The shared package `german_pkg` holds:
  - the command and cache-state enums;
  - `DATA_W`;
  - a packed message struct {cmd, data}, reused by the home side.
- One sub-module, `german_msg_slot`: a single-entry valid/ready output register, instantiated for Chan1 and for Chan3.

## Test plan
- Load in I: ReqS handshake, then GntS with data 2 → `cpu_rsp_data`=2, `cache_state`=S.
- Store 1 in S: ReqE issued, GntE with data 3 → `cache_state`=E, `cache_data`=1, response data 1.
- Line E with data 2, Inv arrives → `chan3_cmd`=4 and `chan3_data`=2, held until `chan3_ready`; `cache_state`=I.
- Inv while in WAIT for ReqE → InvAck with data 0, FSM stays WAIT; a later GntE completes normally.
- Second Inv while Chan3 is stalled → `chan2_ready`=0 until the Chan3 handshake completes.
- GntS in IDLE → `proto_err`=1 with state and data unchanged; assert `reset` mid-WAIT → all reset values next sample.
